// File: rtl/core_pkg.sv
// Shared opcode/funct3 constants, ALU operation and writeback-select types for the core.
package core_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4,
    WB_LUI
  } wb_sel_t;

  // funct3 values shared by the R-type and I-type arithmetic groups
  function automatic logic f3_is_alu(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
           (f3 == F3_OR)  || (f3 == F3_AND);
  endfunction

  function automatic alu_op_t f3_to_op(input logic [2:0] f3);
    case (f3)
      F3_SLT:  return ALU_SLT;
      F3_XOR:  return ALU_XOR;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational 32-bit ALU: add/sub/and/or/xor/signed slt, wrapping arithmetic, zero flag on result.
module core_alu
  import core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = a + b;
    case (op)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'b0);

endmodule

// File: rtl/core.sv
// Single-cycle RV32I subset core; all state commits on the rising clk edge that ends the instruction.
// Defining CORE_DBG_PORT_EN adds a combinational debug read port (dbg_reg_addr/dbg_reg_data).
module core
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] ram_read_data,
  output logic [31:0] pc,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  output logic        ram_write_en
`ifdef CORE_DBG_PORT_EN
  ,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data
`endif
);

  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [31:0] u_imm;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'b0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'b0 : regs[rs2];

  logic    rf_we;
  wb_sel_t wb_sel;
  logic    use_imm;
  alu_op_t alu_op;
  logic    is_store;
  logic    is_beq;
  logic    is_jal;

  // Anything not explicitly matched below falls through as a NOP
  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    use_imm  = 1'b0;
    alu_op   = ALU_ADD;
    is_store = 1'b0;
    is_beq   = 1'b0;
    is_jal   = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op = funct7[5] ? ALU_SUB : f3_to_op(funct3);
        rf_we  = f3_is_alu(funct3) &&
                 ((funct7 == 7'b0000000) || (funct7 == 7'b0100000 && funct3 == F3_ADD));
      end
      OP_I: begin
        alu_op  = f3_to_op(funct3);
        use_imm = 1'b1;
        rf_we   = f3_is_alu(funct3);
      end
      OP_LOAD: begin
        rf_we  = (funct3 == F3_WORD);
        wb_sel = WB_MEM;
      end
      OP_STORE: is_store = (funct3 == F3_WORD);
      OP_BRANCH: begin
        alu_op = ALU_SUB;
        is_beq = (funct3 == F3_BEQ);
      end
      OP_JAL: begin
        rf_we  = 1'b1;
        wb_sel = WB_PC4;
        is_jal = 1'b1;
      end
      OP_LUI: begin
        rf_we  = 1'b1;
        wb_sel = WB_LUI;
      end
      default: rf_we = 1'b0;
    endcase
  end

  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  assign alu_b = use_imm ? i_imm : rs2_val;

  core_alu u_alu (
    .a      (rs1_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] wb_data;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal)
      next_pc = pc + j_imm;
    else if (is_beq && alu_zero)
      next_pc = pc + b_imm;
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = ram_read_data;
      WB_PC4:  wb_data = pc_plus4;
      WB_LUI:  wb_data = u_imm;
      default: wb_data = alu_result;
    endcase
  end

  // Address uses the S-immediate only for stores so lw/sw both see rs1 + their own offset
  assign ram_addr       = rs1_val + ((opcode == OP_STORE) ? s_imm : i_imm);
  assign ram_write_data = rs2_val;
  assign ram_write_en   = is_store && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'b0;
    end else begin
      pc <= next_pc;
      if (rf_we && (rd != 5'd0))
        regs[rd] <= wb_data;
    end
  end

`ifdef CORE_DBG_PORT_EN
  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'b0 : regs[dbg_reg_addr];
`endif

endmodule

// File: tb/tb_core.sv
// Bench for core: directed vector table, reset/branch sequences and a random run against a mnemonic-level model.
module tb_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] ram_read_data;
  logic [31:0] pc;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_write_en;

  int checks = 0;
  int errors = 0;

  core dut (
    .clk            (clk),
    .reset          (reset),
    .instr          (instr),
    .ram_read_data  (ram_read_data),
    .pc             (pc),
    .ram_addr       (ram_addr),
    .ram_write_data (ram_write_data),
    .ram_write_en   (ram_write_en)
  );

  always #50 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] mreg [32];
  logic [31:0] mpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  // ---------------- drive / observe ----------------
  // A reserved-opcode word whose rs2 field selects the register to show on ram_write_data
  task automatic read_reg(input int n, output logic [31:0] v);
    logic [4:0] r;
    r = n[4:0];
    instr = {7'b0, r, 5'b0, 3'b0, 5'b0, 7'b1111111};
    #1;
    v = ram_write_data;
  endtask

  task automatic check_reg(input string name, input int n, input logic [31:0] exp);
    logic [31:0] v;
    read_reg(n, v);
    check($sformatf("%s x%0d", name, n), v, exp);
  endtask

  task automatic sweep(input string name);
    for (int n = 0; n < 32; n++)
      check_reg(name, n, (n == 0) ? 32'b0 : mreg[n]);
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] rdata);
    instr         = ins;
    ram_read_data = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] ins;
    logic [31:0] rdata;
    int          reg_idx;
    logic [31:0] reg_exp;
    logic [31:0] pc_exp;
    logic        we_exp;
    logic        mem_chk;
    logic [31:0] addr_exp;
    logic [31:0] wdata_exp;
  } vec_t;

  vec_t tbl [8];

  // ---------------- random run ----------------
  task automatic random_run(input int count);
    for (int it = 0; it < count; it++) begin
      int          k;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
      logic [31:0] sx, a, b, ins, rdata, val, npc;
      logic        wr, we_exp, addr_chk;
      logic [31:0] addr_exp;
      logic [12:0] bimm;
      logic [20:0] jimm;
      logic [19:0] uimm;

      k     = $urandom_range(0, 16);
      rd    = 5'($urandom_range(0, 31));
      rs1   = 5'($urandom_range(0, 31));
      rs2   = 5'($urandom_range(0, 31));
      imm   = 12'($urandom);
      sx    = 32'($signed(imm));
      a     = mreg[rs1];
      b     = mreg[rs2];
      rdata = $urandom;
      wr    = 1'b0;
      val   = 32'b0;
      npc   = mpc + 32'd4;
      we_exp   = 1'b0;
      addr_chk = 1'b0;
      addr_exp = 32'b0;
      ins      = 32'h0000_007F;

      case (k)
        0:  begin ins = enc_r(7'h00, 3'b000, rd, rs1, rs2); wr = 1; val = a + b; end
        1:  begin ins = enc_r(7'h20, 3'b000, rd, rs1, rs2); wr = 1; val = a - b; end
        2:  begin ins = enc_r(7'h00, 3'b111, rd, rs1, rs2); wr = 1; val = a & b; end
        3:  begin ins = enc_r(7'h00, 3'b110, rd, rs1, rs2); wr = 1; val = a | b; end
        4:  begin ins = enc_r(7'h00, 3'b100, rd, rs1, rs2); wr = 1; val = a ^ b; end
        5:  begin ins = enc_r(7'h00, 3'b010, rd, rs1, rs2); wr = 1;
                  val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6:  begin ins = enc_i(7'b0010011, 3'b000, rd, rs1, imm); wr = 1; val = a + sx; end
        7:  begin ins = enc_i(7'b0010011, 3'b111, rd, rs1, imm); wr = 1; val = a & sx; end
        8:  begin ins = enc_i(7'b0010011, 3'b110, rd, rs1, imm); wr = 1; val = a | sx; end
        9:  begin ins = enc_i(7'b0010011, 3'b100, rd, rs1, imm); wr = 1; val = a ^ sx; end
        10: begin ins = enc_i(7'b0010011, 3'b010, rd, rs1, imm); wr = 1;
                  val = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
        11: begin uimm = 20'($urandom); ins = enc_u(rd, uimm); wr = 1; val = {uimm, 12'b0}; end
        12: begin ins = enc_i(7'b0000011, 3'b010, rd, rs1, imm); wr = 1; val = rdata;
                  addr_chk = 1; addr_exp = a + sx; end
        13: begin ins = enc_s(3'b010, rs1, rs2, imm); we_exp = 1;
                  addr_chk = 1; addr_exp = a + sx; end
        14: begin
              if ($urandom_range(0, 1) == 1) rs2 = rs1;
              b    = mreg[rs2];
              bimm = 13'($urandom) & ~13'd1;
              ins  = enc_b(rs1, rs2, bimm);
              if (a == b) npc = mpc + 32'($signed(bimm));
            end
        15: begin
              jimm = 21'($urandom) & ~21'd1;
              ins  = enc_j(rd, jimm);
              wr   = 1; val = mpc + 32'd4;
              npc  = mpc + 32'($signed(jimm));
            end
        default: begin
          case ($urandom_range(0, 5))
            0: ins = {25'($urandom), 7'b1111111};
            1: ins = enc_r(7'h00, 3'b001, rd, rs1, rs2);
            2: ins = enc_i(7'b0010011, 3'b001, rd, rs1, imm);
            3: ins = enc_i(7'b0000011, 3'b000, rd, rs1, imm);
            4: ins = enc_r(7'h20, 3'b111, rd, rs1, rs2);
            default: ins = enc_s(3'b000, rs1, rs2, imm);
          endcase
        end
      endcase

      present(ins, rdata);
      check("rnd we", {31'b0, ram_write_en}, {31'b0, we_exp});
      if (addr_chk) check("rnd addr", ram_addr, addr_exp);
      if (k == 13) check("rnd wdata", ram_write_data, b);
      tick();
      if (wr && rd != 5'd0) mreg[rd] = val;
      mpc = npc;
      check("rnd pc", pc, mpc);
      check_reg("rnd rd", int'(ins[11:7]), (ins[11:7] == 5'd0) ? 32'b0 : mreg[ins[11:7]]);
      if (it % 64 == 63) sweep("rnd sweep");
    end
  endtask

  initial begin
    reset         = 1'b1;
    instr         = 32'h0000_007F;
    ram_read_data = 32'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'b0;
    #3 reset = 1'b0;
    tick();
    tick();
    check("reset pc", pc, 32'h0);
    check("reset we", {31'b0, ram_write_en}, 32'b0);
    sweep("reset regs");

    // First edge after release runs addi x2,x0,5
    reset = 1'b1;
    tbl[0] = '{32'h00500113, 32'd0, 2, 32'd5,  32'd4,  1'b0, 1'b0, 32'd0, 32'd0};
    tbl[1] = '{32'h00C00193, 32'd0, 3, 32'd12, 32'd8,  1'b0, 1'b0, 32'd0, 32'd0};
    tbl[2] = '{32'hFF718393, 32'd0, 7, 32'd3,  32'd12, 1'b0, 1'b0, 32'd0, 32'd0};
    tbl[3] = '{32'h0023E233, 32'd0, 4, 32'd7,  32'd16, 1'b0, 1'b0, 32'd0, 32'd0};
    tbl[4] = '{32'h0041F2B3, 32'd0, 5, 32'd4,  32'd20, 1'b0, 1'b0, 32'd0, 32'd0};
    tbl[5] = '{32'h004282B3, 32'd0, 5, 32'd11, 32'd24, 1'b0, 1'b0, 32'd0, 32'd0};
    tbl[6] = '{enc_s(3'b010, 5'd0, 5'd2, 12'd8), 32'd0, 1, 32'd0, 32'd28, 1'b1, 1'b1, 32'd8, 32'd5};
    tbl[7] = '{enc_i(7'b0000011, 3'b010, 5'd6, 5'd0, 12'd8), 32'd5, 6, 32'd5, 32'd32, 1'b0, 1'b1, 32'd8, 32'd0};

    for (int i = 0; i < 8; i++) begin
      present(tbl[i].ins, tbl[i].rdata);
      check($sformatf("vec%0d we", i), {31'b0, ram_write_en}, {31'b0, tbl[i].we_exp});
      if (tbl[i].mem_chk) begin
        check($sformatf("vec%0d addr", i), ram_addr, tbl[i].addr_exp);
        check($sformatf("vec%0d wdata", i), ram_write_data, tbl[i].wdata_exp);
      end
      tick();
      check($sformatf("vec%0d pc", i), pc, tbl[i].pc_exp);
      check_reg($sformatf("vec%0d", i), tbl[i].reg_idx, tbl[i].reg_exp);
    end

    // Writes to x0 are dropped; a reserved opcode only advances pc
    present(enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd7), 32'd0);
    tick();
    check("x0 write pc", pc, 32'd36);
    check_reg("x0 write", 0, 32'd0);
    present(32'hFFFF_FFFF, 32'hDEAD_BEEF);
    check("bad op we", {31'b0, ram_write_en}, 32'b0);
    tick();
    check("bad op pc", pc, 32'd40);
    mreg[2] = 32'd5; mreg[3] = 32'd12; mreg[4] = 32'd7;
    mreg[5] = 32'd11; mreg[6] = 32'd5; mreg[7] = 32'd3;
    sweep("after table");

    // Reset asserted between edges clears state immediately and holds it
    present(enc_s(3'b010, 5'd0, 5'd2, 12'd8), 32'd0);
    reset = 1'b0;
    #1;
    check("async reset pc", pc, 32'd0);
    check("async reset we", {31'b0, ram_write_en}, 32'b0);
    for (int i = 0; i < 32; i++) mreg[i] = 32'b0;
    sweep("async reset");
    present(32'h00500113, 32'd0);
    tick();
    check("held reset pc", pc, 32'd0);
    check_reg("held reset", 2, 32'd0);

    // Branch and jump sequence from a fresh start
    reset = 1'b1;
    present(32'h00500113, 32'd0);
    tick();
    check("restart pc", pc, 32'd4);
    check_reg("restart", 2, 32'd5);
    present(enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd7), 32'd0);
    tick();
    check("pre-beq pc", pc, 32'd8);
    present(enc_b(5'd0, 5'd0, 13'd16), 32'd0);
    tick();
    check("beq taken pc", pc, 32'd24);
    present(enc_j(5'd1, 21'h1FFFF8), 32'd0);
    tick();
    check("jal pc", pc, 32'd16);
    check_reg("jal link", 1, 32'd28);
    present(enc_b(5'd2, 5'd0, 13'd16), 32'd0);
    tick();
    check("beq not taken pc", pc, 32'd20);
    present(enc_b(5'd2, 5'd2, 13'h1FF4), 32'd0);
    tick();
    check("beq backward pc", pc, 32'd8);

    // Random run from a clean reset
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = 32'b0;
    mpc = 32'd0;
    check("rnd start pc", pc, 32'd0);
    random_run(400);
    sweep("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 RESET_PC, 32'h0000_0000, pc value loaded on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 instr  input  32  RV32I instruction at address pc, valid combinationally in the same cycle.
REQ-005 ram_read_data  input  32  data memory read word at ram_addr, combinational.
REQ-006 pc  output  32  current instruction address.
REQ-007 ram_addr  output  32  data memory byte address, rs1 + immediate.
REQ-008 ram_write_data  output  32  store data, the rs2 value.
REQ-009 ram_write_en  output  1  high only while executing sw.

Function
REQ-010 Single-cycle: decode, execute and register/memory write complete in the cycle the instruction is presented; state updates on rising clk.
REQ-011 Register file: 32 x 32-bit, two combinational read ports, one write port written on rising clk; x0 reads 0 and writes to it are discarded.
REQ-012 Supported R-type (opcode 0110011): add, sub, and, or, xor, slt (signed), selected by funct3/funct7[5].
REQ-013 Supported I-type (0010011): addi, andi, ori, xori, slti (signed); immediate sign-extended from instr[31:20].
REQ-014 lw (0000011, funct3 010): rd <= ram_read_data; sw (0100011, funct3 010): ram_write_en=1, no register write.
REQ-015 beq (1100011, funct3 000): pc <= pc + B-immediate when rs1 == rs2, else pc + 4.
REQ-016 jal (1101111): rd <= pc + 4, pc <= pc + J-immediate; lui (0110111): rd <= {instr[31:12], 12'b0}.
REQ-017 All other pc updates: pc <= pc + 4; arithmetic wraps modulo 2^32, overflow ignored.
REQ-018 Unsupported opcode/funct: treated as NOP — no register write, ram_write_en=0, pc <= pc + 4.
REQ-019 ram_addr and ram_write_data are driven combinationally for every instruction; only ram_write_en qualifies them.
REQ-020 Same-cycle read-after-write: reads in a cycle see values written at the preceding edge (no internal forwarding needed).

Reset
REQ-021 reset low asynchronously forces pc = RESET_PC and all registers to 0, at any time including mid-instruction.
REQ-022 While reset is low: no register write; ram_write_en = 0.
REQ-023 First instruction executes on the first rising clk with reset high.

Configuration
REQ-024 CORE_DBG_PORT_EN defined: adds input dbg_reg_addr (5) and output dbg_reg_data (32), a combinational third read port of the register file (x0 reads 0).
REQ-025 CORE_DBG_PORT_EN undefined: neither port exists; functional behaviour identical.

Structure
REQ-026 Package core_pkg holds opcode constants, funct3 constants and the ALU-operation enum typedef.
REQ-027 One sub-module core_alu (operands a, b, op; result, zero flag); decoder, immediate generator and register file stay in core.

Verification
REQ-028 Reset low then high, instr=addi x2,x0,5 (32'h00500113), one edge -> x2=5, pc=4.
REQ-029 Sequence 00500113, 00C00193, FF718393, 0023E233, 0041F2B3, 004282B3, one per cycle -> x2=5, x3=12, x7=3, x4=7, x5=4 then x5=11, pc=24.
REQ-030 x2=5, sw x2,8(x0) -> ram_write_en=1, ram_addr=8, ram_write_data=5; x1 unchanged; lw x6,8(x0) with ram_read_data=5 -> x6=5, ram_write_en=0.
REQ-031 beq x0,x0,+16 at pc=8 -> pc=24; beq with x2=5,x0 -> pc+4; jal x1,-8 at pc=24 -> pc=16, x1=28.
REQ-032 addi x0,x0,7 -> x0 reads 0; opcode 7'b1111111 -> no state change except pc+4.
REQ-033 Assert reset low between clock edges mid-sequence -> pc and all registers 0 immediately, before the next edge.
